// File: rtl/mac_row_ctrl.sv
// Sequencer for one mac_row: loads col kernel weights, then streams num_act
// activations, then drains the row with col bubbles before pulsing done.
module mac_row_ctrl #(
  parameter int bw     = 4,
  parameter int col    = 2,
  parameter int cnt_bw = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [cnt_bw-1:0] num_act,
  input  logic [bw-1:0]     w_data,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [bw-1:0]     x_data,
  input  logic              x_valid,
  output logic              x_ready,
  output logic [bw-1:0]     in_w,
  output logic [1:0]        inst_w,
  output logic              busy,
  output logic              done
);

  localparam int WCW = $clog2(col + 1);
  localparam logic [WCW-1:0] W_LAST = WCW'(col - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_GAP, S_EXEC, S_DRAIN, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [WCW-1:0]    wcnt_q, wcnt_d;
  logic [cnt_bw-1:0] xcnt_q, xcnt_d;
  logic [cnt_bw-1:0] nact_q, nact_d;
  logic [bw-1:0]     in_w_q, in_w_d;
  logic [1:0]        inst_w_q, inst_w_d;
  logic              done_q, done_d;

  logic              w_acc, x_acc, x_last, job_go;
  logic [cnt_bw-1:0] xcnt_inc;

  assign w_acc    = w_valid & w_ready;
  assign x_acc    = x_valid & x_ready;
  assign xcnt_inc = xcnt_q + cnt_bw'(1);
  // Equality against the captured count, so the counter never needs to wrap.
  assign x_last   = (xcnt_inc == nact_q);
  assign job_go   = start & (num_act != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (job_go) state_d = S_LOAD;
      S_LOAD:  if (w_acc && wcnt_q == W_LAST) state_d = S_GAP;
      S_GAP:   state_d = S_EXEC;
      S_EXEC:  if (x_acc && x_last) state_d = S_DRAIN;
      S_DRAIN: if (wcnt_q == W_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready  = (state_q == S_LOAD);
    x_ready  = (state_q == S_EXEC);
    busy     = (state_q != S_IDLE);
    in_w_d   = '0;
    inst_w_d = 2'b00;
    done_d   = (state_d == S_DONE);
    wcnt_d   = wcnt_q;
    xcnt_d   = xcnt_q;
    nact_d   = nact_q;
    case (state_q)
      S_IDLE: if (job_go) begin
        nact_d = num_act;
        wcnt_d = '0;
        xcnt_d = '0;
      end
      S_LOAD: if (w_acc) begin
        in_w_d   = w_data;
        inst_w_d = 2'b01;
        wcnt_d   = (wcnt_q == W_LAST) ? '0 : wcnt_q + WCW'(1);
      end
      S_EXEC: if (x_acc) begin
        in_w_d   = x_data;
        inst_w_d = 2'b10;
        xcnt_d   = xcnt_inc;
      end
      // The weight counter is free after LOAD and times the drain bubbles.
      S_DRAIN: wcnt_d = (wcnt_q == W_LAST) ? '0 : wcnt_q + WCW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_w_q   <= '0;
      inst_w_q <= 2'b00;
      done_q   <= 1'b0;
      wcnt_q   <= '0;
      xcnt_q   <= '0;
      nact_q   <= '0;
    end else begin
      in_w_q   <= in_w_d;
      inst_w_q <= inst_w_d;
      done_q   <= done_d;
      wcnt_q   <= wcnt_d;
      xcnt_q   <= xcnt_d;
      nact_q   <= nact_d;
    end
  end

  assign in_w   = in_w_q;
  assign inst_w = inst_w_q;
  assign done   = done_q;

endmodule
